// File: rtl/z_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : z_result_fifo
// Purpose  : Circular result buffer for 2*DATA_W-bit ALU results, read out as
//            two DATA_W halves. Pop happens when the head has been fully read
//            (PAIR_POP=1) or on a low-half read (PAIR_POP=0). Sticky overflow
//            and underflow flags record dropped pushes and reads while empty.
// Revision : 1.0 - initial release
// ============================================================================
module z_result_fifo #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int PAIR_POP = 1
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [2*DATA_W-1:0]        D,
    input  logic                       enable,
    input  logic                       ZLowOut,
    input  logic                       ZHighOut,
    output logic [DATA_W-1:0]          ZLowData,
    output logic [DATA_W-1:0]          ZHighData,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Read-tracking state for the head entry; EMPTY exactly when count is 0.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        HEAD    = 2'd1,
        LO_SEEN = 2'd2,
        HI_SEEN = 2'd3
    } state_t;

    logic [2*DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic                r_overflow;
    logic                r_underflow;
    state_t              r_state;

    state_t              w_state_nxt;
    logic                w_pop;
    logic                w_push;
    logic                w_full;
    logic                w_valid;
    logic [CW-1:0]       w_count_nxt;
    logic [2*DATA_W-1:0] w_head;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_valid = (r_count != '0);

    // Decide pop, accepted push and next read-tracking state for this cycle.
    always_comb begin
        w_pop       = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            HEAD: begin
                if (PAIR_POP != 0) begin
                    if (ZLowOut && ZHighOut) w_pop = 1'b1;
                    else if (ZLowOut)        w_state_nxt = LO_SEEN;
                    else if (ZHighOut)       w_state_nxt = HI_SEEN;
                end else begin
                    w_pop = ZLowOut;
                end
            end
            LO_SEEN: w_pop = (PAIR_POP != 0) ? ZHighOut : ZLowOut;
            HI_SEEN: w_pop = ZLowOut;
            default: w_pop = 1'b0;
        endcase

        // A pop frees a slot in the same cycle, so a push while full still fits.
        w_push      = enable && (!w_full || w_pop);
        w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

        if (w_pop) begin
            w_state_nxt = (w_count_nxt != '0) ? HEAD : EMPTY;
        end else if ((r_state == EMPTY) && w_push) begin
            w_state_nxt = HEAD;
        end
    end

    // Pointers, occupancy, read-tracking state and sticky flags.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_state     <= EMPTY;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_state <= w_state_nxt;
            if (enable && w_full && !w_pop)                r_overflow  <= 1'b1;
            if ((ZLowOut || ZHighOut) && r_state == EMPTY) r_underflow <= 1'b1;
        end
    end

    // Entry storage; stale contents stay hidden because outputs gate on valid.
    always_ff @(posedge clk) begin
        if (!clr && w_push) r_mem[r_wr_ptr] <= D;
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign ZLowData  = w_valid ? w_head[DATA_W-1:0]        : '0;
    assign ZHighData = w_valid ? w_head[2*DATA_W-1:DATA_W] : '0;
    assign valid     = w_valid;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_z_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_z_result_fifo
// Purpose  : Testbench for z_result_fifo; drives one PAIR_POP=1 and one
//            PAIR_POP=0 instance with shared stimulus, compared against a
//            queue-based reference model of each pop policy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_z_result_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        clr;
    logic [63:0] D;
    logic        enable, ZLowOut, ZHighOut;

    logic [31:0] zl [2];
    logic [31:0] zh [2];
    logic        v  [2];
    logic        f  [2];
    logic [2:0]  c  [2];
    logic        o  [2];
    logic        u  [2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: index 1 = pair-pop policy, index 0 = low-read pop.
    logic [63:0] mq   [2][$];
    bit          sl   [2];
    bit          sh   [2];
    bit          movf [2];
    bit          munf [2];

    always #5 clk = ~clk;

    z_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PAIR_POP(1)) u_dut_pair (
        .clk(clk), .clr(clr), .D(D), .enable(enable),
        .ZLowOut(ZLowOut), .ZHighOut(ZHighOut),
        .ZLowData(zl[1]), .ZHighData(zh[1]), .valid(v[1]), .full(f[1]),
        .count(c[1]), .overflow(o[1]), .underflow(u[1])
    );

    z_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PAIR_POP(0)) u_dut_low (
        .clk(clk), .clr(clr), .D(D), .enable(enable),
        .ZLowOut(ZLowOut), .ZHighOut(ZHighOut),
        .ZLowData(zl[0]), .ZHighData(zh[0]), .valid(v[0]), .full(f[0]),
        .count(c[0]), .overflow(o[0]), .underflow(u[0])
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input int p, input logic mc, input logic me,
                              input logic ml, input logic mh, input logic [63:0] md);
        bit pop;
        bit full_now;
        pop      = 1'b0;
        full_now = (mq[p].size() == DEPTH);
        if (mc) begin
            mq[p].delete();
            sl[p] = 0; sh[p] = 0; movf[p] = 0; munf[p] = 0;
        end else begin
            if (mq[p].size() == 0) begin
                if (ml || mh) munf[p] = 1;
            end else if (p == 0) begin
                pop = ml;
            end else begin
                // The head leaves once both halves have been read, in any order.
                pop = (ml || sl[p]) && (mh || sh[p]);
                if (!pop) begin
                    sl[p] = sl[p] | ml;
                    sh[p] = sh[p] | mh;
                end
            end
            if (pop) begin
                void'(mq[p].pop_front());
                sl[p] = 0; sh[p] = 0;
            end
            if (me) begin
                if (!full_now || pop) mq[p].push_back(md);
                else                  movf[p] = 1;
            end
        end
    endtask

    task automatic compare_dut(input int p);
        logic [63:0] head;
        int          n;
        n    = mq[p].size();
        head = (n > 0) ? mq[p][0] : 64'd0;
        check_val($sformatf("p%0d_zlow", p),  64'(zl[p]), 64'(head[31:0]));
        check_val($sformatf("p%0d_zhigh", p), 64'(zh[p]), 64'(head[63:32]));
        check_val($sformatf("p%0d_valid", p), 64'(v[p]),  64'(n > 0));
        check_val($sformatf("p%0d_full", p),  64'(f[p]),  64'(n == DEPTH));
        check_val($sformatf("p%0d_count", p), 64'(c[p]),  64'(n));
        check_val($sformatf("p%0d_ovf", p),   64'(o[p]),  64'(movf[p]));
        check_val($sformatf("p%0d_unf", p),   64'(u[p]),  64'(munf[p]));
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after rising.
    task automatic step(input logic sc, input logic se, input logic sl_i,
                        input logic sh_i, input logic [63:0] sd);
        @(negedge clk);
        clr = sc; enable = se; ZLowOut = sl_i; ZHighOut = sh_i; D = sd;
        @(posedge clk);
        #1;
        model_step(0, sc, se, sl_i, sh_i, sd);
        model_step(1, sc, se, sl_i, sh_i, sd);
        compare_dut(0);
        compare_dut(1);
    endtask

    initial begin
        clr = 1'b1; enable = 1'b0; ZLowOut = 1'b0; ZHighOut = 1'b0; D = '0;

        // Reset state.
        step(1, 0, 0, 0, 64'd0);
        check_val("reset_count", 64'(c[1]), 64'd0);
        step(0, 0, 0, 0, 64'd0);

        // Single push visible next cycle with split halves.
        step(0, 1, 0, 0, 64'hDEAD_BEEF_1234_5678);
        check_val("push_lo", 64'(zl[1]), 64'h1234_5678);
        check_val("push_hi", 64'(zh[1]), 64'hDEAD_BEEF);

        // Low read, repeated low read, then high read completes the pop.
        step(0, 0, 1, 0, 64'd0);
        check_val("lo_seen_count", 64'(c[1]), 64'd1);
        step(0, 0, 1, 0, 64'd0);
        check_val("lo_repeat_count", 64'(c[1]), 64'd1);
        step(0, 0, 0, 1, 64'd0);
        check_val("pair_pop_valid", 64'(v[1]), 64'd0);

        // Five back-to-back pushes: fifth overflows.
        step(1, 0, 0, 0, 64'd0);
        for (int i = 1; i <= 5; i++) step(0, 1, 0, 0, 64'(i) * 64'h0000_0101_0000_0011);
        check_val("ovf_set", 64'(o[1]), 64'd1);
        // Drain with mixed read orders.
        step(0, 0, 1, 1, 64'd0);
        step(0, 0, 0, 1, 64'd0);
        step(0, 0, 1, 0, 64'd0);
        step(0, 0, 1, 0, 64'd0);
        step(0, 0, 0, 1, 64'd0);
        step(0, 0, 1, 1, 64'd0);
        // Refill across the pointer wrap.
        for (int i = 6; i <= 9; i++) step(0, 1, 0, 0, 64'(i) * 64'h0000_0202_0000_0022);

        // Full buffer: push together with a completing pop.
        step(1, 0, 0, 0, 64'd0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 64'hA0 + 64'(i));
        step(0, 0, 1, 0, 64'd0);
        step(0, 1, 0, 1, 64'hFEED_0000_CAFE_0001);
        check_val("full_pop_push_count", 64'(c[1]), 64'd4);
        check_val("full_pop_push_ovf",   64'(o[1]), 64'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 64'd0);

        // Empty buffer: low read with push.
        step(1, 0, 0, 0, 64'd0);
        step(0, 1, 1, 0, 64'h1111_2222_3333_4444);
        check_val("empty_rd_push_unf",   64'(u[1]), 64'd1);
        check_val("empty_rd_push_count", 64'(c[1]), 64'd1);

        // Clear while in LO_SEEN with three entries, then restart.
        step(1, 0, 0, 0, 64'd0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 64'h5A00 + 64'(i));
        step(0, 0, 1, 0, 64'd0);
        step(1, 1, 1, 1, 64'h7777_7777_7777_7777);
        check_val("clr_count", 64'(c[1]), 64'd0);
        step(0, 1, 0, 0, 64'h0BAD_F00D_0000_0042);
        step(0, 0, 0, 1, 64'd0);
        check_val("restart_head_count", 64'(c[1]), 64'd1);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 35),
                 ($urandom_range(0, 99) < 35),
                 {$urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/z_result_fifo.md
Z_RESULT_FIFO -- requirements
Module: z_result_fifo

Interface
REQ-001 Parameter DATA_W, default 32, width of one result half; the full result is 2*DATA_W bits.
REQ-002 Parameter DEPTH, default 4, number of result entries; a power of two, minimum 2.
REQ-003 Parameter PAIR_POP, default 1, pop policy: 1 = pop after both halves are read; 0 = pop on low-half read.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 clr  input  1  reset, synchronous, active-high, sampled on the rising edge of clk.
REQ-006 D  input  2*DATA_W  ALU result to store; D[DATA_W-1:0] is the low half, D[2*DATA_W-1:DATA_W] is the high half.
REQ-007 enable  input  1  write strobe; pushes D when asserted.
REQ-008 ZLowOut  input  1  read strobe for the low half of the head entry.
REQ-009 ZHighOut  input  1  read strobe for the high half of the head entry.
REQ-010 ZLowData  output  DATA_W  low half of the head entry.
REQ-011 ZHighData  output  DATA_W  high half of the head entry.
REQ-012 valid  output  1  asserted when at least one entry is stored.
REQ-013 full  output  1  asserted when count equals DEPTH.
REQ-014 count  output  $clog2(DEPTH+1)  number of stored entries.
REQ-015 overflow  output  1  sticky flag; set by a push attempted while full.
REQ-016 underflow  output  1  sticky flag; set by a read strobe while empty.

Function
REQ-017 Storage SHALL be a circular buffer with DEPTH entries of 2*DATA_W bits, addressed by write and read pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-018 A push (enable=1, not full) SHALL write D at the write pointer, advance the write pointer, and increment count; the entry is visible at the head on the next cycle (latency 1).
REQ-019 ZLowData and ZHighData SHALL be driven from the head entry; both SHALL be 0 when valid=0.
REQ-020 Per-entry read tracking SHALL use a state machine with states EMPTY, HEAD, LO_SEEN and HI_SEEN.
REQ-021 EMPTY->HEAD SHALL occur on the first push into an empty buffer.
REQ-022 With PAIR_POP=1, HEAD->LO_SEEN SHALL occur on ZLowOut only, and HEAD->HI_SEEN on ZHighOut only.
REQ-023 With PAIR_POP=1, a pop SHALL occur on the completing strobe: ZHighOut from LO_SEEN, ZLowOut from HI_SEEN, or both strobes together from HEAD.
REQ-024 With PAIR_POP=0, a pop SHALL occur on any cycle with ZLowOut=1; ZHighOut alone SHALL cause no state change.
REQ-025 A repeated strobe of an already-seen half (e.g. ZLowOut in LO_SEEN) SHALL be ignored, with no pop and no state change.
REQ-026 A pop SHALL advance the read pointer and decrement count; the next state SHALL be HEAD if entries remain, else EMPTY.
REQ-027 Push and pop in the same cycle SHALL both take effect with count unchanged, including when full; this is not an overflow.
REQ-028 A push while full without a same-cycle pop SHALL be dropped, leaving storage and pointers unchanged, and SHALL set overflow.
REQ-029 A read strobe in EMPTY SHALL be ignored and SHALL set underflow; this includes a same-cycle push into an empty buffer, in which case the push completes.
REQ-030 overflow and underflow SHALL clear only on clr.
REQ-031 count SHALL never exceed DEPTH nor wrap below 0.

Reset
REQ-032 When clr=1 at a rising edge: both pointers, count, overflow and underflow SHALL go to 0, state SHALL go to EMPTY, and valid, full, ZLowData and ZHighData SHALL read 0 on the next cycle.
REQ-033 clr SHALL take priority over simultaneous enable, ZLowOut and ZHighOut; entries in flight are discarded.
REQ-034 Storage contents need not be cleared, but SHALL be unobservable until rewritten.

Verification
REQ-035 DATA_W=32: push D=64'hDEAD_BEEF_1234_5678 -> next cycle ZLowData=32'h1234_5678, ZHighData=32'hDEAD_BEEF, count=1, valid=1.
REQ-036 PAIR_POP=1, one entry: ZLowOut, then ZHighOut one cycle later -> count goes 1,1,0 and valid falls after the ZHighOut cycle; a repeated ZLowOut in LO_SEEN does not pop.
REQ-037 DEPTH=4: push 5 distinct values back-to-back -> full=1 after the 4th push; the 5th push sets overflow; reads return values 1..4 in order and the pointers wrap correctly on a refill.
REQ-038 Full buffer: push together with a completing pop -> count stays 4, overflow stays 0, and the new value is read back last.
REQ-039 Empty buffer: ZLowOut and enable together -> the push completes, underflow=1, count=1.
REQ-040 clr asserted while in LO_SEEN with 3 entries -> next cycle count=0, valid=0, both flags 0, outputs 0; the next push starts from state HEAD.
